// File: rtl/button_debouncer.sv
// Push-button debouncer: samples the raw button every PRESCALE clocks and
// changes level only after STABLE_COUNT consecutive opposite samples.
// Optional 2-flop input synchroniser enabled by defining BUTTON_DEBOUNCER_SYNC_EN.
module button_debouncer #(
    parameter int PRESCALE     = 50000,
    parameter int STABLE_COUNT = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic level,
    output logic update
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_COUNT - 1);

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   stab_cnt, stab_cnt_nxt;
    logic [PW-1:0]   pre_cnt;
    logic            sample_en;
    logic            b;

`ifdef BUTTON_DEBOUNCER_SYNC_EN
    // Input synchroniser: two flops ahead of the sampler for asynchronous pins
    logic button_p0, button_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            button_p0 <= 1'b0;
            button_p1 <= 1'b0;
        end else begin
            button_p0 <= button;
            button_p1 <= button_p0;
        end
    end

    assign b = button_p1;
`else
    assign b = button;
`endif

    // Prescaler: one sample point every PRESCALE clocks
    assign sample_en = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (sample_en) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    always_comb begin
        state_nxt    = state;
        stab_cnt_nxt = stab_cnt;
        if (sample_en) begin
            case (state)
                S_LOW: begin
                    if (b) begin
                        state_nxt    = S_RISE;
                        stab_cnt_nxt = SW'(1);
                    end
                end
                S_RISE: begin
                    if (!b) begin
                        state_nxt    = S_LOW;
                        stab_cnt_nxt = '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        state_nxt    = S_HIGH;
                        stab_cnt_nxt = '0;
                    end else begin
                        stab_cnt_nxt = stab_cnt + SW'(1);
                    end
                end
                S_HIGH: begin
                    if (!b) begin
                        state_nxt    = S_FALL;
                        stab_cnt_nxt = SW'(1);
                    end
                end
                S_FALL: begin
                    if (b) begin
                        state_nxt    = S_HIGH;
                        stab_cnt_nxt = '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        state_nxt    = S_LOW;
                        stab_cnt_nxt = '0;
                    end else begin
                        stab_cnt_nxt = stab_cnt + SW'(1);
                    end
                end
                default: begin
                    state_nxt    = S_LOW;
                    stab_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Level is taken from the next state so it moves on the same edge as update
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_LOW;
            stab_cnt <= '0;
            level    <= 1'b0;
            update   <= 1'b0;
        end else begin
            state    <= state_nxt;
            stab_cnt <= stab_cnt_nxt;
            level    <= (state_nxt == S_HIGH) || (state_nxt == S_FALL);
            update   <= sample_en;
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (PRESCALE=4, STABLE_COUNT=3) with an
// expected-level queue popped at each update strobe.
module tb_button_debouncer;

    localparam int PRESCALE     = 4;
    localparam int STABLE_COUNT = 3;
`ifdef BUTTON_DEBOUNCER_SYNC_EN
    localparam int GLITCH_AT = 2;
`else
    localparam int GLITCH_AT = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic button;
    logic level;
    logic update;

    int   compared   = 0;
    int   mismatched = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    button_debouncer #(
        .PRESCALE    (PRESCALE),
        .STABLE_COUNT(STABLE_COUNT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .button(button),
        .level (level),
        .update(update)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one sample value, expect the given level at the next update pulse.
    // With glitch set, the button is held low at the sample point and pulsed
    // high for two clocks strictly between sample points.
    task automatic sample(input logic b, input logic exp_lvl, input bit glitch, input string tag);
        int   n;
        logic got;
        logic exp;
        button = glitch ? 1'b0 : b;
        exp_q.push_back(exp_lvl);
        n   = 0;
        got = 1'b0;
        while (n < 2 * PRESCALE && !got) begin
            if (glitch && n == GLITCH_AT)     button = 1'b1;
            if (glitch && n == GLITCH_AT + 2) button = 1'b0;
            @(negedge clk);
            n++;
            if (update === 1'b1) got = 1'b1;
        end
        if (glitch) button = 1'b0;
        check({tag, "/period"}, 32'(n), 32'(PRESCALE));
        exp = exp_q.pop_front();
        check({tag, "/level"}, {31'b0, level}, {31'b0, exp});
    endtask

    task automatic do_reset(input int cycles, input string tag);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        check({tag, "/rst_level"}, {31'b0, level}, 32'd0);
        check({tag, "/rst_update"}, {31'b0, update}, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        button = 1'b0;
        reset  = 1'b1;

        // Reset and idle
        do_reset(3, "t1");
        sample(1'b0, 1'b0, 1'b0, "t1_s1");
        sample(1'b0, 1'b0, 1'b0, "t1_s2");
        sample(1'b0, 1'b0, 1'b0, "t1_s3");

        // Steady press
        sample(1'b1, 1'b0, 1'b0, "t2_s1");
        sample(1'b1, 1'b0, 1'b0, "t2_s2");
        sample(1'b1, 1'b1, 1'b0, "t2_s3");
        sample(1'b1, 1'b1, 1'b0, "t2_s4");

        // Release
        sample(1'b0, 1'b1, 1'b0, "t5_s1");
        sample(1'b0, 1'b1, 1'b0, "t5_s2");
        sample(1'b0, 1'b0, 1'b0, "t5_s3");

        // Bounce aborts the rise
        sample(1'b1, 1'b0, 1'b0, "t3_s1");
        sample(1'b1, 1'b0, 1'b0, "t3_s2");
        sample(1'b0, 1'b0, 1'b0, "t3_s3");
        sample(1'b1, 1'b0, 1'b0, "t3_s4");
        sample(1'b1, 1'b0, 1'b0, "t3_s5");
        sample(1'b1, 1'b1, 1'b0, "t3_s6");

        // Bounce aborts the fall
        sample(1'b0, 1'b1, 1'b0, "t5b_s1");
        sample(1'b1, 1'b1, 1'b0, "t5b_s2");
        sample(1'b0, 1'b1, 1'b0, "t5b_s3");
        sample(1'b0, 1'b1, 1'b0, "t5b_s4");
        sample(1'b0, 1'b0, 1'b0, "t5b_s5");

        // Glitch between sample points leaves the FSM in S_LOW
        sample(1'b0, 1'b0, 1'b1, "t4_glitch");
        sample(1'b1, 1'b0, 1'b0, "t4_s1");
        sample(1'b1, 1'b0, 1'b0, "t4_s2");
        sample(1'b0, 1'b0, 1'b0, "t4_s3");

        // Reset in the middle of a rise
        sample(1'b1, 1'b0, 1'b0, "t6_s1");
        sample(1'b1, 1'b0, 1'b0, "t6_s2");
        do_reset(3, "t6");
        sample(1'b1, 1'b0, 1'b0, "t6_s3");
        sample(1'b1, 1'b0, 1'b0, "t6_s4");
        sample(1'b1, 1'b1, 1'b0, "t6_s5");

        // Reset coinciding with the sample point suppresses the update pulse
        repeat (PRESCALE - 1) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t7/no_update", {31'b0, update}, 32'd0);
        check("t7/level", {31'b0, level}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        sample(1'b0, 1'b0, 1'b0, "t7_s1");

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
